stage5_round_pack: RTL and testbench

//  Parametrised final stage of the SD4 MAC pipeline: takes the normalised sum, signed

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_round_inc.sv | 24 ++
 rtl/stage5_round_pack.sv | 171 +++++++++++++++++
 tb/tb_stage5_round_pack.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point rounding types and constants.
// Rounding-mode enum, exception flag bit positions, FP16 defaults, bias helper.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rnd_mode_e;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_EXT_W = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// fp_round_inc: round-increment decision from L/G/S, sign and mode.
// Ports: lsb_i, guard_i, sticky_i, sign_i, mode_i in; inc_o out (comb).
module fp_round_inc
  import fp_pkg::*;
(
  input  logic      lsb_i,
  input  logic      guard_i,
  input  logic      sticky_i,
  input  logic      sign_i,
  input  rnd_mode_e mode_i,
  output logic      inc_o
);

  always_comb begin
    inc_o = 1'b0;
    unique case (mode_i)
      RM_RNE: inc_o = guard_i & (sticky_i | lsb_i);
      RM_RTZ: inc_o = 1'b0;
      RM_RUP: inc_o = ~sign_i & (guard_i | sticky_i);
      RM_RDN: inc_o = sign_i & (guard_i | sticky_i);
    endcase
  end

endmodule

// File: rtl/stage5_round_pack.sv
// stage5_round_pack: MAC final stage, align/denormalise (S1), round+pack (S2).
// Ports: in_valid/in_ready beat in, out_valid/out_ready result out, flags.
module stage5_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W    = FP16_EXP_W,
  parameter int MAN_W    = FP16_MAN_W,
  parameter int EXT_W    = FP16_EXT_W,
  parameter int EXP_IN_W = EXP_W + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_IN_W-1:0]    exp_final,
  input  logic                   sign,
  input  logic [MAN_W+EXT_W:0]   norm_sum,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [2:0]             out_flags,
  output logic [2:0]             acc_flags,
  input  logic                   flag_clr
);

  localparam int NW = MAN_W + 1 + EXT_W;
  localparam int XW = EXP_IN_W + 1;
  localparam logic [XW-1:0] SH_ONE  = XW'(1);
  localparam logic [XW-1:0] SH_LIM  = XW'(NW);
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [MAN_W-1:0] M_ONES = '1;

  typedef struct packed {
    logic                sgn;
    logic                zero;
    logic                tiny;
    logic [EXP_IN_W-1:0] exp;
    logic [MAN_W:0]      mant;
    logic                l;
    logic                g;
    logic                s;
    rnd_mode_e           mode;
  } s1_t;

  // handshake
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic fire_in, s1_adv;

  assign in_ready = ~s1_v_q | ~s2_v_q | out_ready;
  assign fire_in  = in_valid & in_ready;
  assign s1_adv   = s1_v_q & (~s2_v_q | out_ready);
  assign s1_v_d   = fire_in | (s1_v_q & ~s1_adv);
  assign s2_v_d   = s1_adv | (s2_v_q & ~out_ready);

  // S1: align
  s1_t              s1_d, s1_q;
  logic             tiny, lost;
  logic [XW-1:0]    sh;
  logic [NW-1:0]    m;

  always_comb begin
    tiny = exp_final[EXP_IN_W-1] | (exp_final == '0);
    sh   = SH_ONE - {exp_final[EXP_IN_W-1], exp_final};
    m    = norm_sum;
    lost = 1'b0;
    if (tiny) begin
      if (sh > SH_LIM) begin
        m    = '0;
        lost = |norm_sum;
      end else begin
        m    = norm_sum >> sh;
        lost = |(norm_sum & ~({NW{1'b1}} << sh));
      end
    end
    s1_d.sgn  = sign;
    s1_d.zero = ~norm_sum[NW-1];
    s1_d.tiny = tiny;
    s1_d.exp  = tiny ? '0 : exp_final;
    s1_d.mant = m[NW-1:EXT_W];
    s1_d.l    = m[EXT_W];
    s1_d.g    = m[EXT_W-1];
    // round bit and everything below it fold into sticky
    s1_d.s    = (|m[EXT_W-2:0]) | lost;
    s1_d.mode = rnd_mode_e'(rnd_mode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (fire_in) s1_q <= s1_d;
    end
  end

  // S2: round and pack
  logic                  inc, bump, inx, ovf, to_inf;
  logic [MAN_W+1:0]      mant_r;
  logic [XW-1:0]         exp_post;
  logic [EXP_W+MAN_W:0]  res_d, res_q;
  logic [2:0]            flg_d, flg_q;
  logic [2:0]            acc_d, acc_q;

  fp_round_inc u_inc (
    .lsb_i    (s1_q.l),
    .guard_i  (s1_q.g),
    .sticky_i (s1_q.s),
    .sign_i   (s1_q.sgn),
    .mode_i   (s1_q.mode),
    .inc_o    (inc)
  );

  always_comb begin
    mant_r = {1'b0, s1_q.mant} + {{(MAN_W+1){1'b0}}, inc};
    // carry out of 1.f, or subnormal rounding up into the hidden bit
    bump   = mant_r[MAN_W+1] | (s1_q.tiny & mant_r[MAN_W]);
    exp_post = {1'b0, s1_q.exp} + {{(XW-1){1'b0}}, bump};
    inx    = s1_q.g | s1_q.s;
    ovf    = exp_post >= EXP_MAX;
    to_inf = (s1_q.mode == RM_RNE)
           | ((s1_q.mode == RM_RUP) & ~s1_q.sgn)
           | ((s1_q.mode == RM_RDN) & s1_q.sgn);
    res_d  = {s1_q.sgn, exp_post[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flg_d  = '0;
    if (s1_q.zero) begin
      res_d = {s1_q.sgn, {(EXP_W+MAN_W){1'b0}}};
    end else if (ovf) begin
      res_d = to_inf ? {s1_q.sgn, E_ONES, {MAN_W{1'b0}}}
                     : {s1_q.sgn, E_ONES - 1'b1, M_ONES};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else begin
      flg_d[FLG_UNF] = s1_q.tiny & inx;
      flg_d[FLG_INX] = inx;
    end
  end

  // a flag_clr coinciding with a consumed result keeps that result's flags
  always_comb begin
    acc_d = acc_q;
    if (s2_v_q & out_ready)
      acc_d = flag_clr ? flg_q : (acc_q | flg_q);
    else if (flag_clr)
      acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
      acc_q  <= '0;
    end else begin
      s2_v_q <= s2_v_d;
      acc_q  <= acc_d;
      if (s1_adv) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out       = res_q;
  assign out_flags = flg_q;
  assign acc_flags = acc_q;

endmodule

// File: tb/tb_stage5_round_pack.sv
// tb_stage5_round_pack: scoreboard bench for stage5_round_pack (FP16 defaults).
// Directed beats push expected {out,flags}; a negedge monitor pops and compares.
module tb_stage5_round_pack;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  exp_final = '0;
  logic        sign = 1'b0;
  logic [13:0] norm_sum = '0;
  logic [1:0]  rnd_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_w;
  logic [2:0]  out_flags;
  logic [2:0]  acc_flags;
  logic        flag_clr = 1'b0;

  always #5 clk = ~clk;

  stage5_round_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_final (exp_final),
    .sign      (sign),
    .norm_sum  (norm_sum),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .out_flags (out_flags),
    .acc_flags (acc_flags),
    .flag_clr  (flag_clr)
  );

  logic [18:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic [2:0]  acc_m = '0;
  logic        hold = 1'b0;
  logic [18:0] hold_v = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor + acc_flags reference model
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst) begin
      acc_m = '0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_data", {13'b0, out_w, out_flags}, {13'b0, hold_v});
      end
      chk("acc_flags", {29'b0, acc_flags}, {29'b0, acc_m});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_out: got %h want none", out_w);
        end else begin
          e = exp_q.pop_front();
          chk("result", {13'b0, out_w, out_flags}, {13'b0, e});
          acc_m = flag_clr ? e[2:0] : (acc_m | e[2:0]);
        end
      end else if (flag_clr) begin
        acc_m = '0;
      end
      hold   = out_valid & ~out_ready;
      hold_v = {out_w, out_flags};
    end
  end

  task automatic send(input logic [6:0] e, input logic s,
                      input logic [13:0] ns, input rnd_mode_e md,
                      input logic [15:0] eo, input logic [2:0] ef,
                      input bit keep);
    int k;
    exp_final = e;
    sign      = s;
    norm_sum  = ns;
    rnd_mode  = md;
    in_valid  = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 want 1");
    end else begin
      n_acc++;
      if (keep) exp_q.push_back({eo, ef});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      k++;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_out", {16'b0, out_w}, 0);
    chk("rst_flags", {29'b0, out_flags}, 0);
    chk("rst_acc", {29'b0, acc_flags}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    send(7'd15, 0, 14'h2000, RM_RNE, 16'h3C00, 3'b000, 1);
    send(7'd15, 0, 14'h3FFC, RM_RNE, 16'h4000, 3'b001, 1);
    send(7'd15, 0, 14'h3FFC, RM_RTZ, 16'h3FFF, 3'b001, 1);
    send(7'd31, 0, 14'h2000, RM_RNE, 16'h7C00, 3'b101, 1);
    send(7'd31, 0, 14'h2000, RM_RTZ, 16'h7BFF, 3'b101, 1);
    send(7'd31, 1, 14'h2000, RM_RDN, 16'hFC00, 3'b101, 1);
    send(7'd31, 1, 14'h2000, RM_RUP, 16'hFBFF, 3'b101, 1);
    send(7'd30, 0, 14'h3FFC, RM_RNE, 16'h7C00, 3'b101, 1);
    send(7'h7F, 0, 14'h2000, RM_RNE, 16'h0100, 3'b000, 1);
    send(7'h7F, 0, 14'h2001, RM_RNE, 16'h0100, 3'b011, 1);
    send(7'd0,  0, 14'h2000, RM_RNE, 16'h0200, 3'b000, 1);
    send(7'd0,  0, 14'h3FFC, RM_RNE, 16'h0400, 3'b011, 1);
    send(7'h77, 0, 14'h2000, RM_RNE, 16'h0001, 3'b000, 1);
    send(7'h76, 0, 14'h2000, RM_RNE, 16'h0000, 3'b011, 1);
    send(7'h76, 0, 14'h2000, RM_RUP, 16'h0001, 3'b011, 1);
    send(7'h73, 0, 14'h2000, RM_RNE, 16'h0000, 3'b011, 1);
    send(7'h6C, 0, 14'h2000, RM_RNE, 16'h0000, 3'b011, 1);
    send(7'h6C, 0, 14'h2000, RM_RUP, 16'h0001, 3'b011, 1);
    send(7'd15, 1, 14'h0000, RM_RNE, 16'h8000, 3'b000, 1);
    send(7'd15, 0, 14'h2004, RM_RNE, 16'h3C00, 3'b001, 1);
    send(7'd15, 1, 14'h2001, RM_RDN, 16'hBC01, 3'b001, 1);
    send(7'd15, 1, 14'h2001, RM_RUP, 16'hBC00, 3'b001, 1);
    drain();

    // flag_clr in the same cycle as an overflow result is consumed
    send(7'd15, 0, 14'h2004, RM_RNE, 16'h3C00, 3'b001, 1);
    send(7'd31, 0, 14'h2000, RM_RNE, 16'h7C00, 3'b101, 1);
    @(posedge clk);
    #1;
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("clr_with_event", {29'b0, acc_flags}, 32'h5);
    drain();

    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("clr_alone", {29'b0, acc_flags}, 0);
    send(7'd15, 0, 14'h2004, RM_RNE, 16'h3C00, 3'b001, 1);
    drain();

    // backpressure: 4 stalled cycles, 3 beats offered
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'b0, in_ready}, 0);
        chk("stall_accepted", n_acc - base, 2);
        out_ready = 1'b1;
      end
    join_none
    send(7'd15, 0, 14'h2000, RM_RNE, 16'h3C00, 3'b000, 1);
    send(7'd16, 1, 14'h2000, RM_RNE, 16'hC000, 3'b000, 1);
    send(7'd15, 0, 14'h3FFC, RM_RTZ, 16'h3FFF, 3'b001, 1);
    drain();

    // async reset with both stages full
    out_ready = 1'b0;
    send(7'd15, 0, 14'h2001, RM_RNE, 16'h3C00, 3'b001, 0);
    send(7'd15, 0, 14'h2001, RM_RNE, 16'h3C00, 3'b001, 0);
    chk("full_valid", {31'b0, out_valid}, 1);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    chk("pre_rst_acc", {31'b0, acc_flags != 3'b000}, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_acc", {29'b0, acc_flags}, 0);
    chk("arst_out", {16'b0, out_w}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(7'd15, 0, 14'h2000, RM_RNE, 16'h3C00, 3'b000, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
